// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings and flag bit positions
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;
  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational BLOCK-bit carry-lookahead group with group generate/propagate
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);
  logic [BLOCK-1:0] gv, pv;
  logic [BLOCK:0] c;
  logic t;
  // every carry is a flat sum of products of generate/propagate terms, no ripple chain
  always_comb begin
    gv = a & b;
    pv = a ^ b;
    c = '0;
    t = 1'b0;
    g = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      c[i] = cin;
      for (int k = 0; k < i; k++) c[i] = c[i] & pv[k];
      for (int j = 0; j < i; j++) begin
        t = gv[j];
        for (int k = j + 1; k < i; k++) t = t & pv[k];
        c[i] = c[i] | t;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      t = gv[j];
      for (int k = j + 1; k < BLOCK; k++) t = t & pv[k];
      g = g | t;
    end
    p = &pv;
    sum = pv ^ c[BLOCK-1:0];
    cout = c[BLOCK];
  end
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: add/sub with one BLOCK-bit lookahead group per pipeline stage,
// valid/ready on both sides and C/V/Z/N flags formed from the last stage.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);
  localparam int BLK = BLOCK < 1 ? 1 : BLOCK;
  localparam int NSTG = WIDTH / BLK;
  if (BLOCK < 1) begin : g_bad_block
    $error("pipelined_cla_addsub: BLOCK must be at least 1");
  end else if (WIDTH % BLK != 0) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK");
  end
  logic adv;
  logic cin;
  logic [WIDTH-1:0] bp;
  logic [3:0] flg;
  always_comb begin
    adv = !out_valid || out_ready;
    bp = in_op[0] ? ~in_b : in_b;
    cin = in_op == OP_ADD ? 1'b0 : in_op == OP_SUB ? 1'b1 : in_c;
  end
  assign in_ready = adv;
  for (genvar s = 0; s < NSTG; s++) begin : stg
    localparam int HI = WIDTH - (s + 1) * BLK;
    logic [WIDTH-s*BLK-1:0] xi, yi;
    logic vi, ci, ami, bmi;
    logic [BLK-1:0] gs;
    logic gco, gg, gp;
    logic v_q, v_d, c_q, c_d, am_q, am_d, bm_q, bm_d;
    logic [(s+1)*BLK-1:0] s_q, s_d;
    if (s == 0) begin : g_src
      always_comb begin
        xi = in_a;
        yi = bp;
        vi = in_valid;
        ci = cin;
        ami = in_a[WIDTH-1];
        bmi = bp[WIDTH-1];
        s_d = adv ? gs : s_q;
      end
    end else begin : g_src
      always_comb begin
        xi = stg[s-1].g_up.x_q;
        yi = stg[s-1].g_up.y_q;
        vi = stg[s-1].v_q;
        ci = stg[s-1].c_q;
        ami = stg[s-1].am_q;
        bmi = stg[s-1].bm_q;
        s_d = adv ? {gs, stg[s-1].s_q} : s_q;
      end
    end
    cla_group #(.BLOCK(BLK)) u_grp (
      .a   (xi[BLK-1:0]),
      .b   (yi[BLK-1:0]),
      .cin (ci),
      .sum (gs),
      .cout(gco),
      .g   (gg),
      .p   (gp)
    );
    always_comb assert (gco == (gg | (gp & ci)));
    always_comb begin
      v_d = adv ? vi : v_q;
      c_d = adv ? gco : c_q;
      am_d = adv ? ami : am_q;
      bm_d = adv ? bmi : bm_q;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {v_q, c_q, am_q, bm_q, s_q} <= '0;
      else {v_q, c_q, am_q, bm_q, s_q} <= {v_d, c_d, am_d, bm_d, s_d};
    // operand bits not yet consumed travel alongside their partial sum
    if (HI > 0) begin : g_up
      logic [HI-1:0] x_q, x_d, y_q, y_d;
      always_comb begin
        x_d = adv ? xi[WIDTH-s*BLK-1:BLK] : x_q;
        y_d = adv ? yi[WIDTH-s*BLK-1:BLK] : y_q;
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {x_q, y_q} <= '0;
        else {x_q, y_q} <= {x_d, y_d};
    end
  end
  always_comb begin
    out_valid = stg[NSTG-1].v_q;
    out_sum = stg[NSTG-1].s_q;
    flg = '0;
    flg[FLG_C] = stg[NSTG-1].c_q;
    flg[FLG_V] = (stg[NSTG-1].am_q == stg[NSTG-1].bm_q) && (out_sum[WIDTH-1] != stg[NSTG-1].am_q);
    flg[FLG_Z] = out_valid && out_sum == '0;
    flg[FLG_N] = out_sum[WIDTH-1];
    out_c = flg[FLG_C];
    out_v = flg[FLG_V];
    out_z = flg[FLG_Z];
    out_n = flg[FLG_N];
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: scoreboard bench for 8-bit and 16-bit pipelined add/sub instances
module tb_pipelined_cla_addsub;
  import alu_pkg::*;
  typedef struct packed {
    logic [15:0] sum;
    logic c, v, z, n;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic iv8 = 1'b0, ic8 = 1'b0, or8 = 1'b1, ir8, ov8, oc8, ovf8, oz8, on8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic [1:0] op8 = '0;
  logic iv16 = 1'b0, ic16 = 1'b0, or16 = 1'b1, ir16, ov16, oc16, ovf16, oz16, on16;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic [1:0] op16 = '0;
  exp_t q8[$], q16[$];
  int checks = 0, errors = 0;
  bit done = 1'b0;
  pipelined_cla_addsub #(.WIDTH(8), .BLOCK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_c(ic8),
    .in_op(op8), .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_c(oc8), .out_v(ovf8),
    .out_z(oz8), .out_n(on8)
  );
  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_c(ic16),
    .in_op(op16), .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_c(oc16), .out_v(ovf16),
    .out_z(oz16), .out_n(on16)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic [1:0] op);
    logic [16:0] full;
    logic [15:0] m, bp;
    logic ci;
    m = w == 16 ? 16'hFFFF : 16'h00FF;
    bp = (op[0] ? ~b : b) & m;
    ci = op == OP_ADD ? 1'b0 : op == OP_SUB ? 1'b1 : c;
    full = {1'b0, a & m} + {1'b0, bp} + {16'd0, ci};
    model.sum = full[15:0] & m;
    model.c = full[w];
    model.n = model.sum[w-1];
    model.z = model.sum == 16'd0;
    model.v = (a[w-1] == bp[w-1]) && (model.sum[w-1] != a[w-1]);
  endfunction
  task automatic send(input bit w, input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [1:0] op, input logic [15:0] es, input logic ec, input logic ev,
                      input logic ez, input logic en);
    exp_t e;
    e = '{sum: es, c: ec, v: ev, z: ez, n: en};
    if (w) begin
      iv16 = 1'b1; a16 = a; b16 = b; ic16 = c; op16 = op;
    end else begin
      iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; ic8 = c; op8 = op;
    end
    for (int t = 0; t < 50; t++) begin
      #1;
      if (w ? ir16 : ir8) begin
        if (w) q16.push_back(e);
        else q8.push_back(e);
        @(negedge clk);
        iv8 = 1'b0;
        iv16 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    iv8 = 1'b0;
    iv16 = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic send_rand16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [1:0] op);
    exp_t e;
    e = model(16, a, b, c, op);
    send(1'b1, a, b, c, op, e.sum, e.c, e.v, e.z, e.n);
  endtask
  task automatic drain();
    for (int t = 0; t < 100 && (q8.size() != 0 || q16.size() != 0); t++) @(negedge clk);
    chk("drain", 32'(q8.size() + q16.size()), 32'd0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    fork
      begin : monitor
        exp_t e;
        bit stall8 = 1'b0;
        logic [12:0] hold8 = '0;
        while (!done) begin
          @(negedge clk);
          #2;
          if (!rst_n) stall8 = 1'b0;
          else begin
            if (stall8) chk("hold8", 32'({ov8, s8, oc8, ovf8, oz8, on8}), 32'(hold8));
            if (ov8 && !or8) begin
              chk("in_ready_stall8", 32'(ir8), 32'd0);
              stall8 = 1'b1;
              hold8 = {ov8, s8, oc8, ovf8, oz8, on8};
            end else stall8 = 1'b0;
            if (ov8 && or8) begin
              if (q8.size() == 0) chk("unexpected8", 32'(s8), 32'hDEAD);
              else begin
                e = q8.pop_front();
                chk("sum8", 32'(s8), 32'(e.sum[7:0]));
                chk("flags8_cvzn", 32'({oc8, ovf8, oz8, on8}), 32'({e.c, e.v, e.z, e.n}));
              end
            end
            if (ov16 && or16) begin
              if (q16.size() == 0) chk("unexpected16", 32'(s16), 32'hDEAD);
              else begin
                e = q16.pop_front();
                chk("sum16", 32'(s16), 32'(e.sum));
                chk("flags16_cvzn", 32'({oc16, ovf16, oz16, on16}), 32'({e.c, e.v, e.z, e.n}));
              end
            end
          end
        end
      end
      begin : stimulus
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_out8", 32'({s8, oc8, ovf8, oz8, on8}), 32'd0);
        chk("rst_in_ready8", 32'(ir8), 32'd1);
        chk("rst_out16", 32'({ov16, s16, oc16, ovf16, oz16, on16}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_idle8", 32'(ir8), 32'd1);
        send(1'b0, 16'd10, 16'd15, 1'b0, OP_ADD, 16'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("latency8_early", 32'(ov8), 32'd0);
        @(negedge clk);
        #1 chk("latency8_valid", 32'(ov8), 32'd1);
        chk("latency8_sum", 32'(s8), 32'd25);
        send(1'b0, 16'd210, 16'd199, 1'b0, OP_ADD, 16'd153, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 16'd210, 16'd199, 1'b1, OP_ADC, 16'd154, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 16'd15, 16'd10, 1'b0, OP_SUB, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 16'd10, 16'd15, 1'b0, OP_SUB, 16'd251, 1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 16'd128, 16'd1, 1'b0, OP_SUB, 16'd127, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b0, 16'd0, 16'd0, 1'b0, OP_SBC, 16'd255, 1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 16'd5, 16'd5, 1'b0, OP_SUB, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        or8 = 1'b0;
        fork
          begin
            send(1'b0, 16'd1, 16'd2, 1'b0, OP_ADD, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
            send(1'b0, 16'd100, 16'd100, 1'b0, OP_ADD, 16'd200, 1'b0, 1'b1, 1'b0, 1'b1);
            send(1'b0, 16'd3, 16'd3, 1'b0, OP_SUB, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            send(1'b0, 16'd255, 16'd0, 1'b1, OP_ADC, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
          end
          begin
            for (int t = 0; t < 20 && !ov8; t++) @(negedge clk);
            chk("stall_seen_valid8", 32'(ov8), 32'd1);
            repeat (3) @(negedge clk);
            or8 = 1'b1;
          end
        join
        drain();
        send(1'b0, 16'd1, 16'd1, 1'b0, OP_ADD, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 16'd2, 16'd2, 1'b0, OP_ADD, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("pre_reset_valid8", 32'(ov8), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_valid8", 32'(ov8), 32'd0);
        chk("async_reset_in_ready8", 32'(ir8), 32'd1);
        q8.delete();
        q16.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
          @(negedge clk);
          #1 chk("post_reset_quiet8", 32'(ov8), 32'd0);
        end
        @(negedge clk);
        send(1'b0, 16'd9, 16'd4, 1'b0, OP_SUB, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        send(1'b1, 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int t = 1; t < 4; t++) begin
          #1 chk("latency16_early", 32'(ov16), 32'd0);
          @(negedge clk);
        end
        #1 chk("latency16_valid", 32'(ov16), 32'd1);
        chk("latency16_sum", 32'(s16), 32'd0);
        @(negedge clk);
        send(1'b1, 16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 16'h1234, 16'h4321, 1'b1, OP_ADC, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        fork
          begin
            for (int i = 0; i < 40; i++)
              send_rand16(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
          end
          begin
            for (int t = 0; t < 80; t++) begin
              @(negedge clk);
              or16 = 1'($urandom_range(0, 3) != 0);
            end
            or16 = 1'b1;
          end
        join
        or16 = 1'b1;
        drain();
        done = 1'b1;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
